bsg_acm_cipher_core: RTL and testbench

Parametrised Arnold Cat Map image cipher core, the successor to the single-bit cell array.
- Holds a board_width_p x board_width_p image of pixel_width_p-bit pixels.
- Applies a requested number of forward (encrypt) or inverse (decrypt) cat-map iterations, one per cycle.
- Uses ready/valid input and valid/yumi output handshakes.
- Sits between the image load/unload datapath and the chip I/O wrapper.

---
 rtl/bsg_acm_pkg.sv | 13 +
 rtl/bsg_acm_permute.sv | 35 +++
 rtl/bsg_acm_cipher_core.sv | 109 ++++++++++
 tb/tb_bsg_acm_cipher_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_acm_pkg.sv
// Shared types for the Arnold Cat Map cipher core: FSM states and map direction codes.
package bsg_acm_pkg;

    typedef enum logic [1:0] {
        eIdle = 2'd0,
        eBusy = 2'd1,
        eDone = 2'd2
    } acm_state_e;

    localparam logic e_acm_fwd = 1'b0;
    localparam logic e_acm_inv = 1'b1;

endpackage

// File: rtl/bsg_acm_permute.sv
// One cat-map iteration over the whole image, forward or inverse, as pure wiring plus a mux.
module bsg_acm_permute #(
    parameter int board_width_p = 8,
    parameter int pixel_width_p = 8,
    localparam int cells_lp = board_width_p * board_width_p,
    localparam int data_width_lp = cells_lp * pixel_width_p
) (
    input  logic [data_width_lp-1:0] data_i,
    input  logic                     inv_i,
    output logic [data_width_lp-1:0] data_o
);

    logic [data_width_lp-1:0] fwd_data;
    logic [data_width_lp-1:0] inv_data;

    // Source indices are elaboration-time constants; the W offsets keep the inverse operands non-negative.
    for (genvar x = 0; x < board_width_p; x++) begin : g_row
        for (genvar y = 0; y < board_width_p; y++) begin : g_col
            localparam int k_lp  = x * board_width_p + y;
            localparam int fx_lp = (x + y) % board_width_p;
            localparam int fy_lp = (x + 2 * y) % board_width_p;
            localparam int ix_lp = (2 * x + board_width_p - y) % board_width_p;
            localparam int iy_lp = (y + board_width_p - x) % board_width_p;
            localparam int fk_lp = fx_lp * board_width_p + fy_lp;
            localparam int ik_lp = ix_lp * board_width_p + iy_lp;

            assign fwd_data[k_lp*pixel_width_p +: pixel_width_p] = data_i[fk_lp*pixel_width_p +: pixel_width_p];
            assign inv_data[k_lp*pixel_width_p +: pixel_width_p] = data_i[ik_lp*pixel_width_p +: pixel_width_p];
            assign data_o[k_lp*pixel_width_p +: pixel_width_p] =
                inv_i ? inv_data[k_lp*pixel_width_p +: pixel_width_p]
                      : fwd_data[k_lp*pixel_width_p +: pixel_width_p];
        end
    end

endmodule

// File: rtl/bsg_acm_cipher_core.sv
// Arnold Cat Map image cipher core: accepts an image job, iterates one map step per cycle, holds the result.
module bsg_acm_cipher_core
    import bsg_acm_pkg::*;
#(
    parameter int board_width_p = 8,
    parameter int pixel_width_p = 8,
    parameter int max_iter_p    = 255,
    localparam int iter_width_lp = $clog2(max_iter_p + 1),
    localparam int data_width_lp = board_width_p * board_width_p * pixel_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [data_width_lp-1:0] data_i,
    input  logic [iter_width_lp-1:0] iter_i,
    input  logic                     decrypt_i,
    output logic                     v_o,
    output logic [data_width_lp-1:0] data_o,
    input  logic                     yumi_i
);

    acm_state_e               state_r;
    acm_state_e               state_n;
    logic [iter_width_lp-1:0] cnt_r;
    logic                     mode_r;
    logic [data_width_lp-1:0] data_r;
    logic [data_width_lp-1:0] step_data;

    bsg_acm_permute #(
        .board_width_p(board_width_p),
        .pixel_width_p(pixel_width_p)
    ) permute (
        .data_i(data_r),
        .inv_i (mode_r),
        .data_o(step_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_r)
            eIdle: begin
                ready_o = 1'b1;
                if (v_i) begin
                    state_n = (iter_i != '0) ? eBusy : eDone;
                end
            end
            eBusy: begin
                if (cnt_r == iter_width_lp'(1)) begin
                    state_n = eDone;
                end
            end
            eDone: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_n = eIdle;
                end
            end
            default: state_n = eIdle;
        endcase
    end

    // Inputs are captured only on the accepting edge; mode and count then stay fixed for the job.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r  <= '0;
            mode_r <= e_acm_fwd;
            data_r <= '0;
        end else begin
            case (state_r)
                eIdle: begin
                    if (v_i) begin
                        data_r <= data_i;
                        cnt_r  <= iter_i;
                        mode_r <= decrypt_i;
                    end
                end
                eBusy: begin
                    data_r <= step_data;
                    cnt_r  <= cnt_r - iter_width_lp'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign data_o = data_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i && v_i && ready_o) begin
            assert (int'(iter_i) <= max_iter_p);
        end
        if (!reset_i && yumi_i) begin
            assert (v_o);
        end
    end

endmodule

// File: tb/tb_bsg_acm_cipher_core.sv
// Directed self-checking bench for bsg_acm_cipher_core on a 4x4 image of 8-bit pixels.
module tb_bsg_acm_cipher_core;

    localparam int W   = 4;
    localparam int PW  = 8;
    localparam int N   = W * W;
    localparam int DW  = N * PW;
    localparam int ITW = 8;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           v_i;
    logic           ready_o;
    logic [DW-1:0]  data_i;
    logic [ITW-1:0] iter_i;
    logic           decrypt_i;
    logic           v_o;
    logic [DW-1:0]  data_o;
    logic           yumi_i;

    int n_cmp = 0;
    int n_err = 0;

    bsg_acm_cipher_core #(
        .board_width_p(W),
        .pixel_width_p(PW),
        .max_iter_p   (255)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .iter_i   (iter_i),
        .decrypt_i(decrypt_i),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one job and clocks the accepting edge; afterwards the bench sits in cycle 1.
    task automatic applyStimulus(input logic [DW-1:0] img, input int iter, input logic dec);
        v_i       = 1'b1;
        data_i    = img;
        iter_i    = ITW'(iter);
        decrypt_i = dec;
        checkOutput("ready_at_accept", DW'(ready_o), DW'(1));
        tick();
        v_i    = 1'b0;
        data_i = '0;
    endtask

    function automatic logic [DW-1:0] model_step(input logic [DW-1:0] img, input logic inv);
        logic [DW-1:0] r;
        int sx, sy;
        r = '0;
        for (int x = 0; x < W; x++) begin
            for (int y = 0; y < W; y++) begin
                if (!inv) begin
                    sx = (x + y) % W;
                    sy = (x + 2 * y) % W;
                end else begin
                    sx = (2 * x + W - y) % W;
                    sy = (y + W - x) % W;
                end
                r[(x*W+y)*PW +: PW] = img[(sx*W+sy)*PW +: PW];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] model_run(input logic [DW-1:0] img, input int iter, input logic inv);
        logic [DW-1:0] r;
        r = img;
        for (int i = 0; i < iter; i++) r = model_step(r, inv);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_img();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Waits (bounded) for v_o and checks it rose exactly iter cycles after the accepting cycle.
    task automatic waitDone(input string tag, input int iter);
        int lat;
        lat = 0;
        while (!v_o && lat < 300) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, DW'(lat), DW'(iter));
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    logic [DW-1:0] img;
    logic [DW-1:0] res;
    logic [DW-1:0] exp_img;
    int            it;
    logic          dec;

    initial begin
        reset_i   = 1'b1;
        v_i       = 1'b0;
        data_i    = '0;
        iter_i    = '0;
        decrypt_i = 1'b0;
        yumi_i    = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready", DW'(ready_o), DW'(1));
        checkOutput("reset_v", DW'(v_o), DW'(0));
        checkOutput("reset_data", data_o, '0);
        reset_i = 1'b0;
        tick();

        // Ramp image, one forward step: hand-computed cells.
        for (int k = 0; k < N; k++) img[k*PW +: PW] = PW'(k);
        applyStimulus(img, 1, 1'b0);
        waitDone("ramp_fwd1", 1);
        checkOutput("ramp_cell6", DW'(data_o[6*PW +: PW]), DW'(13));
        checkOutput("ramp_cell0", DW'(data_o[0*PW +: PW]), DW'(0));
        checkOutput("ramp_cell1", DW'(data_o[1*PW +: PW]), DW'(6));
        checkOutput("ramp_full", data_o, model_step(img, 1'b0));
        consume();

        // Forward period for a 4x4 board is 3.
        img = rand_img();
        applyStimulus(img, 3, 1'b0);
        waitDone("period3", 3);
        checkOutput("period3_data", data_o, img);
        consume();

        // Forward 5 then inverse 5 restores the image.
        img = rand_img();
        applyStimulus(img, 5, 1'b0);
        waitDone("fwd5", 5);
        res = data_o;
        checkOutput("fwd5_data", res, model_run(img, 5, 1'b0));
        consume();
        applyStimulus(res, 5, 1'b1);
        waitDone("inv5", 5);
        checkOutput("inv5_restore", data_o, img);
        consume();

        // iter=0 completes in cycle 1 and holds without yumi; v_i pulses are ignored.
        img = rand_img();
        applyStimulus(img, 0, 1'b1);
        checkOutput("iter0_v", DW'(v_o), DW'(1));
        checkOutput("iter0_data", data_o, img);
        for (int c = 0; c < 10; c++) begin
            v_i    = c[0];
            data_i = ~img;
            iter_i = 8'd3;
            tick();
            checkOutput("hold_v", DW'(v_o), DW'(1));
            checkOutput("hold_ready", DW'(ready_o), DW'(0));
            checkOutput("hold_data", data_o, img);
        end
        v_i    = 1'b0;
        data_i = '0;
        consume();

        // Reset in the middle of a long job discards it.
        img = rand_img();
        applyStimulus(img, 50, 1'b0);
        for (int c = 1; c < 20; c++) tick();
        checkOutput("busy_v", DW'(v_o), DW'(0));
        checkOutput("busy_ready", DW'(ready_o), DW'(0));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checkOutput("midreset_ready", DW'(ready_o), DW'(1));
        checkOutput("midreset_v", DW'(v_o), DW'(0));
        checkOutput("midreset_data", data_o, '0);
        img = rand_img();
        applyStimulus(img, 2, 1'b1);
        waitDone("after_reset", 2);
        checkOutput("after_reset_data", data_o, model_run(img, 2, 1'b1));

        // Back-to-back random jobs: yumi in the v_o cycle with the next job already on v_i.
        for (int j = 0; j < 200; j++) begin
            img     = rand_img();
            it      = $urandom_range(0, 6);
            dec     = 1'($urandom);
            exp_img = model_run(img, it, dec);
            v_i       = 1'b1;
            data_i    = img;
            iter_i    = ITW'(it);
            decrypt_i = dec;
            consume();
            applyStimulus(img, it, dec);
            waitDone("b2b", it);
            checkOutput("b2b_data", data_o, exp_img);
        end
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
